// File: rtl/sqrt_fx.sv
// sqrt_fx: iterative fixed-point integer square root.
// Non-restoring digit-by-digit recurrence that resolves UNROLL root bits per
// clock, MSB first. The result has a floor root, a floor remainder and an
// optional round-to-nearest root that saturates at the maximum root value.
module sqrt_fx #(
  parameter int W      = 64,
  parameter int UNROLL = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   x,
  input  logic           round,
  input  logic           start,
  input  logic           abort,
  output logic [W/2-1:0] y,
  output logic [W/2:0]   rem,
  output logic           sat,
  output logic           busy,
  output logic           valid
);

  localparam int H  = W / 2;
  localparam int N  = H / UNROLL;
  // Partial remainder width: magnitude stays within 2*root+1, and the
  // top two bits must remain sign copies so the left shift loses nothing.
  localparam int RW = H + 4;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          r_state;
  logic [W-1:0]    r_x;
  logic            r_round;
  logic [RW-1:0]   r_rem;
  logic [H-1:0]    r_root;
  logic [CW-1:0]   r_cnt;
  logic [H-1:0]    r_y;
  logic [H:0]      r_remo;
  logic            r_sat;
  logic            r_busy;
  logic            r_valid;

  logic [RW-1:0]   w_rem_nxt;
  logic [H-1:0]    w_root_nxt;
  logic [RW-1:0]   w_t;
  logic [H:0]      w_rem_fix;
  logic            w_up;
  logic            w_sat;
  logic [H-1:0]    w_y;

  // UNROLL recurrence steps: add or subtract depending on remainder sign.
  always_comb begin
    w_rem_nxt  = r_rem;
    w_root_nxt = r_root;
    w_t        = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      w_t = {w_rem_nxt[RW-3:0], r_x[W-1-2*i -: 2]};
      if (!w_rem_nxt[RW-1])
        w_rem_nxt = w_t - {2'b00, w_root_nxt, 2'b01};
      else
        w_rem_nxt = w_t + {2'b00, w_root_nxt, 2'b11};
      w_root_nxt = {w_root_nxt[H-2:0], ~w_rem_nxt[RW-1]};
    end
  end

  // Final remainder correction and rounding decision, used on the FIN edge.
  // The corrected remainder always fits H+1 bits, so the modular low-bit sum
  // of the negative partial remainder and 2*root+1 is exact.
  always_comb begin
    w_rem_fix = r_rem[H:0] + ({(H+1){r_rem[RW-1]}} & {r_root, 1'b1});
    w_up      = r_round && (w_rem_fix > {1'b0, r_root});
    w_sat     = w_up && (&r_root);
    w_y       = (w_up && !w_sat) ? r_root + H'(1) : r_root;
  end

  // Control FSM plus datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_round <= 1'b0;
      r_rem   <= '0;
      r_root  <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_remo  <= '0;
      r_sat   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (abort) begin
            r_valid <= 1'b0;
          end else if (start) begin
            r_x     <= x;
            r_round <= round;
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= CW'(N);
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_rem  <= w_rem_nxt;
            r_root <= w_root_nxt;
            r_x    <= {r_x[W-1-2*UNROLL:0], {(2*UNROLL){1'b0}}};
            r_cnt  <= r_cnt - CW'(1);
            if (r_cnt == CW'(1))
              r_state <= FIN;
          end
        end
        FIN: begin
          if (!abort) begin
            r_y     <= w_y;
            r_remo  <= w_rem_fix;
            r_sat   <= w_sat;
            r_valid <= 1'b1;
          end else begin
            r_valid <= 1'b0;
          end
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign y     = r_y;
  assign rem   = r_remo;
  assign sat   = r_sat;
  assign busy  = r_busy;
  assign valid = r_valid;

endmodule

// File: tb/tb_sqrt_fx.sv
// tb_sqrt_fx: directed and swept checks of sqrt_fx in three configurations:
// W=16/UNROLL=1 (a), W=16/UNROLL=2 (b), W=64/UNROLL=1 (c).
module tb_sqrt_fx;

  logic clk = 1'b0;
  logic rst;
  logic abort;

  logic [15:0] a_x;  logic a_round, a_start;
  logic [7:0]  a_y;  logic [8:0] a_rem;  logic a_sat, a_busy, a_valid;
  logic [15:0] b_x;  logic b_round, b_start;
  logic [7:0]  b_y;  logic [8:0] b_rem;  logic b_sat, b_busy, b_valid;
  logic [63:0] c_x;  logic c_round, c_start;
  logic [31:0] c_y;  logic [32:0] c_rem; logic c_sat, c_busy, c_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sqrt_fx #(.W(16), .UNROLL(1)) dut_a (
    .clk(clk), .rst(rst), .x(a_x), .round(a_round), .start(a_start), .abort(abort),
    .y(a_y), .rem(a_rem), .sat(a_sat), .busy(a_busy), .valid(a_valid));

  sqrt_fx #(.W(16), .UNROLL(2)) dut_b (
    .clk(clk), .rst(rst), .x(b_x), .round(b_round), .start(b_start), .abort(1'b0),
    .y(b_y), .rem(b_rem), .sat(b_sat), .busy(b_busy), .valid(b_valid));

  sqrt_fx #(.W(64), .UNROLL(1)) dut_c (
    .clk(clk), .rst(rst), .x(c_x), .round(c_round), .start(c_start), .abort(1'b0),
    .y(c_y), .rem(c_rem), .sat(c_sat), .busy(c_busy), .valid(c_valid));

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [15:0] xv, input logic rnd);
    a_x = xv; a_round = rnd; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic start_b(input logic [15:0] xv, input logic rnd);
    b_x = xv; b_round = rnd; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
  endtask

  task automatic start_c(input logic [63:0] xv, input logic rnd);
    c_x = xv; c_round = rnd; c_start = 1'b1;
    @(posedge clk); #1;
    c_start = 1'b0;
  endtask

  // Linear-search floor root for 16-bit radicands.
  function automatic void ref16(input logic [15:0] xv, input logic rnd,
                                output logic [7:0] ey, output logic [8:0] erem,
                                output logic esat);
    int r = 0;
    int rm;
    while ((r + 1) * (r + 1) <= int'(xv)) r++;
    rm   = int'(xv) - r * r;
    erem = 9'(rm);
    esat = 1'b0;
    ey   = 8'(r);
    if (rnd && rm > r) begin
      if (r == 255) esat = 1'b1;
      else          ey   = 8'(r + 1);
    end
  endfunction

  task automatic test_reset;
    rst = 1'b0; abort = 1'b0;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_x = '0; b_x = '0; c_x = '0; a_round = 1'b0; b_round = 1'b0; c_round = 1'b0;
    #12;
    checks++;
    if ({a_y, a_rem, a_sat, a_busy, a_valid, b_busy, b_valid, c_busy, c_valid, c_y} !== '0) begin
      errors++;
      $display("FAIL reset_state a_y=%0d a_rem=%0d busy=%b valid=%b c_y=%0d expected all zero",
               a_y, a_rem, a_busy, a_valid, c_y);
    end
    rst = 1'b1;
    // Start accepted on the very first edge out of reset.
    start_a(16'd49, 1'b0);
    edges(9);
    checks++;
    if ({a_valid, a_busy, a_y, a_rem, a_sat} !== {1'b1, 1'b0, 8'd7, 9'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_exit_start valid=%b busy=%b y=%0d rem=%0d expected 1 0 7 0",
               a_valid, a_busy, a_y, a_rem);
    end
  endtask

  task automatic test_floor_round;
    logic [15:0] tx [10] = '{16'd24, 16'd24, 16'd0, 16'd2, 16'd3, 16'd56, 16'd57,
                             16'hFFFF, 16'hFFFF, 16'd65025};
    logic        tr [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0]  ty [10] = '{8'd4, 8'd5, 8'd0, 8'd1, 8'd2, 8'd7, 8'd8, 8'd255, 8'd255, 8'd255};
    logic [8:0]  tm [10] = '{9'd8, 9'd8, 9'd0, 9'd1, 9'd2, 9'd7, 9'd8, 9'd510, 9'd510, 9'd0};
    logic        ts [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      start_a(tx[i], tr[i]);
      edges(8);
      checks++;
      if ({a_valid, a_busy} !== 2'b01) begin
        errors++;
        $display("FAIL floor_round_pre[%0d] valid=%b busy=%b expected 0 1", i, a_valid, a_busy);
      end
      edges(1);
      checks++;
      if ({a_valid, a_busy, a_y, a_rem, a_sat} !== {1'b1, 1'b0, ty[i], tm[i], ts[i]}) begin
        errors++;
        $display("FAIL floor_round[%0d] x=%0d rnd=%b got y=%0d rem=%0d sat=%b valid=%b expected y=%0d rem=%0d sat=%b",
                 i, tx[i], tr[i], a_y, a_rem, a_sat, a_valid, ty[i], tm[i], ts[i]);
      end
    end
  endtask

  task automatic test_unroll2;
    for (int i = 0; i < 2; i++) begin
      start_b(16'd24, i[0]);
      edges(4);
      checks++;
      if ({b_valid, b_busy} !== 2'b01) begin
        errors++;
        $display("FAIL unroll2_pre[%0d] valid=%b busy=%b expected 0 1", i, b_valid, b_busy);
      end
      edges(1);
      checks++;
      if ({b_valid, b_busy, b_y, b_rem, b_sat} !== {1'b1, 1'b0, (i == 0) ? 8'd4 : 8'd5, 9'd8, 1'b0}) begin
        errors++;
        $display("FAIL unroll2[%0d] got y=%0d rem=%0d sat=%b valid=%b expected y=%0d rem=8 sat=0",
                 i, b_y, b_rem, b_sat, b_valid, (i == 0) ? 4 : 5);
      end
    end
  endtask

  task automatic test_w64;
    start_c(64'd0, 1'b0);
    edges(32);
    checks++;
    if ({c_valid, c_busy} !== 2'b01) begin
      errors++;
      $display("FAIL w64_zero_pre valid=%b busy=%b expected 0 1", c_valid, c_busy);
    end
    edges(1);
    checks++;
    if ({c_valid, c_busy, c_y, c_rem, c_sat} !== {1'b1, 1'b0, 32'd0, 33'd0, 1'b0}) begin
      errors++;
      $display("FAIL w64_zero got y=%0h rem=%0h sat=%b valid=%b busy=%b expected 0 0 0 1 0",
               c_y, c_rem, c_sat, c_valid, c_busy);
    end
    for (int i = 0; i < 2; i++) begin
      start_c(64'hFFFF_FFFF_FFFF_FFFF, i[0]);
      edges(33);
      checks++;
      if ({c_valid, c_busy, c_y, c_rem, c_sat} !==
          {1'b1, 1'b0, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, i[0]}) begin
        errors++;
        $display("FAIL w64_max[%0d] got y=%0h rem=%0h sat=%b valid=%b expected y=ffffffff rem=1fffffffe sat=%0d",
                 i, c_y, c_rem, c_sat, c_valid, i);
      end
    end
  endtask

  task automatic test_start_ignored;
    start_a(16'd100, 1'b0);
    edges(2);
    a_x = 16'd49; a_start = 1'b1;
    edges(1);
    a_start = 1'b0;
    checks++;
    if ({a_valid, a_busy} !== 2'b01) begin
      errors++;
      $display("FAIL start_ignored_busy valid=%b busy=%b expected 0 1", a_valid, a_busy);
    end
    edges(6);
    checks++;
    if ({a_valid, a_busy, a_y, a_rem, a_sat} !== {1'b1, 1'b0, 8'd10, 9'd0, 1'b0}) begin
      errors++;
      $display("FAIL start_ignored got y=%0d rem=%0d valid=%b busy=%b expected y=10 rem=0 1 0",
               a_y, a_rem, a_valid, a_busy);
    end
  endtask

  task automatic test_abort;
    start_a(16'd100, 1'b0);
    checks++;
    if ({a_valid, a_busy} !== 2'b01) begin
      errors++;
      $display("FAIL accept_drops_valid valid=%b busy=%b expected 0 1", a_valid, a_busy);
    end
    edges(4);
    abort = 1'b1;
    edges(1);
    abort = 1'b0;
    checks++;
    if ({a_valid, a_busy, a_y, a_rem, a_sat} !== {1'b0, 1'b0, 8'd10, 9'd0, 1'b0}) begin
      errors++;
      $display("FAIL abort_calc got valid=%b busy=%b y=%0d rem=%0d expected 0 0 10 0",
               a_valid, a_busy, a_y, a_rem);
    end
    edges(6);
    checks++;
    if ({a_valid, a_busy} !== 2'b00) begin
      errors++;
      $display("FAIL abort_calc_hold valid=%b busy=%b expected 0 0", a_valid, a_busy);
    end
    // Abort during FIN: no result is written.
    start_a(16'd49, 1'b1);
    edges(8);
    abort = 1'b1;
    edges(1);
    abort = 1'b0;
    checks++;
    if ({a_valid, a_busy, a_y, a_rem} !== {1'b0, 1'b0, 8'd10, 9'd0}) begin
      errors++;
      $display("FAIL abort_fin got valid=%b busy=%b y=%0d rem=%0d expected 0 0 10 0",
               a_valid, a_busy, a_y, a_rem);
    end
    // Abort in IDLE clears valid and beats a simultaneous start.
    start_a(16'd49, 1'b0);
    edges(9);
    a_x = 16'd100; a_start = 1'b1; abort = 1'b1;
    edges(1);
    a_start = 1'b0; abort = 1'b0;
    checks++;
    if ({a_valid, a_busy, a_y, a_rem} !== {1'b0, 1'b0, 8'd7, 9'd0}) begin
      errors++;
      $display("FAIL abort_idle got valid=%b busy=%b y=%0d rem=%0d expected 0 0 7 0",
               a_valid, a_busy, a_y, a_rem);
    end
  endtask

  task automatic test_async_reset;
    start_a(16'd100, 1'b0);
    edges(3);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({a_y, a_rem, a_sat, a_busy, a_valid} !== '0) begin
      errors++;
      $display("FAIL async_reset got y=%0d rem=%0d sat=%b busy=%b valid=%b expected all zero",
               a_y, a_rem, a_sat, a_busy, a_valid);
    end
    #2;
    rst = 1'b1;
    start_a(16'd49, 1'b0);
    edges(9);
    checks++;
    if ({a_valid, a_busy, a_y, a_rem, a_sat} !== {1'b1, 1'b0, 8'd7, 9'd0, 1'b0}) begin
      errors++;
      $display("FAIL after_reset got y=%0d rem=%0d valid=%b busy=%b expected 7 0 1 0",
               a_y, a_rem, a_valid, a_busy);
    end
  endtask

  task automatic test_back_to_back;
    start_a(16'd56, 1'b1);
    edges(9);
    checks++;
    if ({a_valid, a_y, a_rem, a_sat} !== {1'b1, 8'd7, 9'd7, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first got y=%0d rem=%0d valid=%b expected 7 7 1", a_y, a_rem, a_valid);
    end
    start_a(16'd57, 1'b1);
    checks++;
    if ({a_valid, a_busy} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_accept valid=%b busy=%b expected 0 1", a_valid, a_busy);
    end
    edges(9);
    checks++;
    if ({a_valid, a_busy, a_y, a_rem, a_sat} !== {1'b1, 1'b0, 8'd8, 9'd8, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second got y=%0d rem=%0d sat=%b valid=%b expected 8 8 0 1",
               a_y, a_rem, a_sat, a_valid);
    end
  endtask

  task automatic test_sweep;
    fork
      begin : sweep_a
        logic [15:0] xv; logic rnd; logic [7:0] ey; logic [8:0] er; logic es;
        for (int i = 0; i < 4000; i++) begin
          xv  = (i % 8 == 0) ? 16'(((i / 8) % 256) * ((i / 8) % 256) + ((i / 16) % 2) * ((i / 8) % 256))
                             : 16'($urandom_range(0, 65535));
          rnd = 1'($urandom_range(0, 1));
          ref16(xv, rnd, ey, er, es);
          start_a(xv, rnd);
          edges(8);
          checks++;
          if ({a_valid, a_busy} !== 2'b01) begin
            errors++;
            $display("FAIL sweep_a_timing x=%0d valid=%b busy=%b expected 0 1", xv, a_valid, a_busy);
          end
          edges(1);
          checks++;
          if ({a_valid, a_busy, a_y, a_rem, a_sat} !== {1'b1, 1'b0, ey, er, es}) begin
            errors++;
            $display("FAIL sweep_a x=%0d rnd=%b got y=%0d rem=%0d sat=%b valid=%b expected y=%0d rem=%0d sat=%b",
                     xv, rnd, a_y, a_rem, a_sat, a_valid, ey, er, es);
          end
        end
      end
      begin : sweep_b
        logic [15:0] xv; logic rnd; logic [7:0] ey; logic [8:0] er; logic es;
        for (int i = 0; i < 6000; i++) begin
          xv  = 16'($urandom_range(0, 65535));
          rnd = 1'($urandom_range(0, 1));
          ref16(xv, rnd, ey, er, es);
          start_b(xv, rnd);
          edges(4);
          checks++;
          if ({b_valid, b_busy} !== 2'b01) begin
            errors++;
            $display("FAIL sweep_b_timing x=%0d valid=%b busy=%b expected 0 1", xv, b_valid, b_busy);
          end
          edges(1);
          checks++;
          if ({b_valid, b_busy, b_y, b_rem, b_sat} !== {1'b1, 1'b0, ey, er, es}) begin
            errors++;
            $display("FAIL sweep_b x=%0d rnd=%b got y=%0d rem=%0d sat=%b valid=%b expected y=%0d rem=%0d sat=%b",
                     xv, rnd, b_y, b_rem, b_sat, b_valid, ey, er, es);
          end
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_floor_round();
    test_unroll2();
    test_w64();
    test_start_ignored();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
